uart_bus_bridge: RTL and testbench

UART_BUS_BRIDGE -- requirements
Module: uart_bus_bridge

---
 rtl/uart_bus_bridge_pkg.sv | 39 +++
 rtl/uart_bridge_shift32.sv | 53 +++++
 rtl/uart_bus_bridge.sv | 259 +++++++++++++++++++++++++
 tb/tb_uart_bus_bridge.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_bus_bridge_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_bus_bridge_pkg                                        |
// | Description : Shared definitions for the UART-to-bus bridge: FSM state   |
// |               encoding, command bytes ('W'/'R'), response bytes          |
// |               ('K'/'?') and bus width defaults.                          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+

`ifndef RISCV_ADDR_WIDTH
`define RISCV_ADDR_WIDTH 32
`endif
`ifndef RISCV_WORD_WIDTH
`define RISCV_WORD_WIDTH 32
`endif

package uart_bus_bridge_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_DATA   = 3'd2,
    ST_BUS    = 3'd3,
    ST_RESP   = 3'd4,
    ST_TXWAIT = 3'd5
  } state_t;

  localparam logic [7:0] CMD_WRITE   = 8'h57;  // 'W'
  localparam logic [7:0] CMD_READ    = 8'h52;  // 'R'
  localparam logic [7:0] RSP_ACK     = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_UNKNOWN = 8'h3F;  // '?'

  localparam logic [3:0] WE_WRITE    = 4'hF;

endpackage

`default_nettype wire

// File: rtl/uart_bridge_shift32.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_bridge_shift32                                        |
// | Description : 32-bit byte shift register. Bytes shifted in enter at the  |
// |               top and move down, so four shifts assemble an LSB-first    |
// |               byte stream into a word; byte_o always presents the low    |
// |               byte so a parallel-loaded word is emitted LSB first.       |
// | Revision    : 1.0 - initial release                                      |
// | Ports       : clk, rst     - clock, async active-high reset              |
// |               load_i/word_i - parallel load (priority over shift)        |
// |               shift_i/byte_i - shift one byte in from the top            |
// |               word_o        - current word                               |
// |               byte_o        - current low byte                           |
// +--------------------------------------------------------------------------+

module uart_bridge_shift32
  import uart_bus_bridge_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [31:0]       word_i,
  input  logic              shift_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [31:0]       word_o,
  output logic [BYTE_W-1:0] byte_o
);

  logic [31:0] word_q, word_d;

  always_comb begin
    word_d = word_q;
    if (load_i) begin
      word_d = word_i;
    end else if (shift_i) begin
      word_d = {byte_i, word_q[31:BYTE_W]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign word_o = word_q;
  assign byte_o = word_q[BYTE_W-1:0];

endmodule

`default_nettype wire

// File: rtl/uart_bus_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_bus_bridge                                            |
// | Description : Byte-stream command bridge from a UART to a simple         |
// |               valid/ready bus. 'W' + addr[4] + data[4] performs a write  |
// |               answered with 'K'; 'R' + addr[4] performs a read answered  |
// |               with the 4 read bytes LSB first; other commands get '?'.   |
// | Revision    : 1.0 - initial release                                      |
// | Config      : UART_BUS_BRIDGE_READ_EN - enables the 'R' command and the  |
// |               read-data capture register.                                |
// | Ports       : clk, rst            - clock, async active-high reset       |
// |               rx_valid_i/rx_byte_i/rx_error_i - UART receive side        |
// |               tx_start_o/tx_byte_o/tx_busy_i  - UART transmit side       |
// |               valid_o/ready_i/addr_o/wdata_o/we_o/rdata_i - bus master   |
// |               busy_o              - frame in progress (FSM not IDLE)     |
// +--------------------------------------------------------------------------+

module uart_bus_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rx_valid_i,
  input  logic [7:0]                   rx_byte_i,
  input  logic                         rx_error_i,
  output logic                         tx_start_o,
  output logic [7:0]                   tx_byte_o,
  input  logic                         tx_busy_i,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [`RISCV_ADDR_WIDTH-1:0] addr_o,
  output logic [`RISCV_WORD_WIDTH-1:0] wdata_o,
  output logic [3:0]                   we_o,
  input  logic [`RISCV_WORD_WIDTH-1:0] rdata_i,
  output logic                         busy_o
);

  import uart_bus_bridge_pkg::*;

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic        is_write_q, is_write_d;
  logic [2:0]  resp_left_q, resp_left_d;   // response bytes still to send
  logic [7:0]  resp_byte_q, resp_byte_d;   // single-byte response ('K'/'?')
  logic        txw_first_q, txw_first_d;   // first TXWAIT cycle: busy not yet valid
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_byte_q, tx_byte_d;

  logic        addr_shift, data_shift;
  logic [7:0]  addr_byte_unused, data_byte_unused;
  logic [7:0]  next_byte;

`ifdef UART_BUS_BRIDGE_READ_EN
  logic        resp_rd_q, resp_rd_d;       // response bytes come from read data
  logic        rd_load, rd_shift;
  logic [7:0]  rd_byte;
  logic [31:0] rd_word_unused;

  assign next_byte = resp_rd_q ? rd_byte : resp_byte_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^rdata_i;
  assign next_byte    = resp_byte_q;
`endif

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    timer_d     = timer_q;
    is_write_d  = is_write_q;
    resp_left_d = resp_left_q;
    resp_byte_d = resp_byte_q;
    txw_first_d = txw_first_q;
    tx_start_d  = 1'b0;
    tx_byte_d   = tx_byte_q;
    addr_shift  = 1'b0;
    data_shift  = 1'b0;
`ifdef UART_BUS_BRIDGE_READ_EN
    resp_rd_d   = resp_rd_q;
    rd_load     = 1'b0;
    rd_shift    = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (rx_valid_i) begin
          byte_cnt_d = 2'd0;
          if (rx_byte_i == CMD_WRITE) begin
            is_write_d = 1'b1;
            state_d    = ST_ADDR;
          end
`ifdef UART_BUS_BRIDGE_READ_EN
          else if (rx_byte_i == CMD_READ) begin
            is_write_d = 1'b0;
            state_d    = ST_ADDR;
          end
`endif
          else begin
            resp_byte_d = RSP_UNKNOWN;
            resp_left_d = 3'd1;
`ifdef UART_BUS_BRIDGE_READ_EN
            resp_rd_d   = 1'b0;
`endif
            state_d     = ST_RESP;
          end
        end
      end

      ST_ADDR, ST_DATA: begin
        // A framing error aborts the frame even if it coincides with a byte.
        if (rx_error_i) begin
          state_d = ST_IDLE;
        end else if (rx_valid_i) begin
          timer_d    = '0;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (state_q == ST_ADDR) begin
            addr_shift = 1'b1;
          end else begin
            data_shift = 1'b1;
          end
          if (byte_cnt_q == 2'd3) begin
            state_d = (state_q == ST_ADDR && is_write_q) ? ST_DATA : ST_BUS;
          end
        end else if (timer_q == TMO_LAST) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      ST_BUS: begin
        if (ready_i) begin
          state_d = ST_RESP;
`ifdef UART_BUS_BRIDGE_READ_EN
          if (!is_write_q) begin
            rd_load     = 1'b1;
            resp_rd_d   = 1'b1;
            resp_left_d = 3'd4;
          end else
`endif
          begin
            resp_byte_d = RSP_ACK;
            resp_left_d = 3'd1;
`ifdef UART_BUS_BRIDGE_READ_EN
            resp_rd_d   = 1'b0;
`endif
          end
        end
      end

      ST_RESP: begin
        if (!tx_busy_i) begin
          tx_start_d  = 1'b1;
          tx_byte_d   = next_byte;
          resp_left_d = resp_left_q - 3'd1;
          txw_first_d = 1'b1;
          state_d     = ST_TXWAIT;
`ifdef UART_BUS_BRIDGE_READ_EN
          rd_shift    = resp_rd_q;
`endif
        end
      end

      ST_TXWAIT: begin
        // The transmitter raises busy one cycle after the start pulse.
        if (txw_first_q) begin
          txw_first_d = 1'b0;
        end else if (!tx_busy_i) begin
          state_d = (resp_left_q != 3'd0) ? ST_RESP : ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      byte_cnt_q  <= '0;
      timer_q     <= '0;
      is_write_q  <= 1'b0;
      resp_left_q <= '0;
      resp_byte_q <= '0;
      txw_first_q <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_byte_q   <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      timer_q     <= timer_d;
      is_write_q  <= is_write_d;
      resp_left_q <= resp_left_d;
      resp_byte_q <= resp_byte_d;
      txw_first_q <= txw_first_d;
      tx_start_q  <= tx_start_d;
      tx_byte_q   <= tx_byte_d;
    end
  end

`ifdef UART_BUS_BRIDGE_READ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_rd_q <= 1'b0;
    end else begin
      resp_rd_q <= resp_rd_d;
    end
  end

  uart_bridge_shift32 u_rdata (
    .clk     (clk),
    .rst     (rst),
    .load_i  (rd_load),
    .word_i  (rdata_i),
    .shift_i (rd_shift),
    .byte_i  (8'h00),
    .word_o  (rd_word_unused),
    .byte_o  (rd_byte)
  );
`endif

  uart_bridge_shift32 u_addr (
    .clk     (clk),
    .rst     (rst),
    .load_i  (1'b0),
    .word_i  (32'h0),
    .shift_i (addr_shift),
    .byte_i  (rx_byte_i),
    .word_o  (addr_o),
    .byte_o  (addr_byte_unused)
  );

  uart_bridge_shift32 u_wdata (
    .clk     (clk),
    .rst     (rst),
    .load_i  (1'b0),
    .word_i  (32'h0),
    .shift_i (data_shift),
    .byte_i  (rx_byte_i),
    .word_o  (wdata_o),
    .byte_o  (data_byte_unused)
  );

  // Bus outputs decode from the state register so an async reset drops
  // valid_o in the same cycle.
  assign valid_o    = (state_q == ST_BUS);
  assign we_o       = (state_q == ST_BUS && is_write_q) ? WE_WRITE : 4'h0;
  assign busy_o     = (state_q != ST_IDLE);
  assign tx_start_o = tx_start_q;
  assign tx_byte_o  = tx_byte_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_bus_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_uart_bus_bridge                                         |
// | Description : Scoreboard bench for uart_bus_bridge. Stimulus pushes the  |
// |               expected bus transactions and transmit bytes into queues;  |
// |               a monitor pops and compares whenever valid_o rises or      |
// |               tx_start_o pulses. Honours UART_BUS_BRIDGE_READ_EN.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+

`ifndef RISCV_ADDR_WIDTH
`define RISCV_ADDR_WIDTH 32
`endif
`ifndef RISCV_WORD_WIDTH
`define RISCV_WORD_WIDTH 32
`endif

module tb_uart_bus_bridge;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid_i, rx_error_i, tx_busy_i, ready_i;
  logic [7:0]  rx_byte_i;
  logic        tx_start_o, valid_o, busy_o;
  logic [7:0]  tx_byte_o;
  logic [31:0] addr_o, wdata_o, rdata_i;
  logic [3:0]  we_o;

  uart_bus_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid_i (rx_valid_i),
    .rx_byte_i  (rx_byte_i),
    .rx_error_i (rx_error_i),
    .tx_start_o (tx_start_o),
    .tx_byte_o  (tx_byte_o),
    .tx_busy_i  (tx_busy_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .addr_o     (addr_o),
    .wdata_o    (wdata_o),
    .we_o       (we_o),
    .rdata_i    (rdata_i),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
  } bus_exp_t;

  bus_exp_t    exp_bus[$];
  logic [7:0]  exp_tx[$];

  int          checks = 0;
  int          errors = 0;

  int          ready_delay_fixed = -1;   // -1: random responder latency
  bit          ready_hold = 1'b0;        // never complete (reset test)
  bit          use_fixed_rdata = 1'b0;
  logic [31:0] fixed_rdata = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  bus_exp_t    e;
  logic        prev_valid = 1'b0;
  logic [31:0] held_addr, held_wdata;
  logic [3:0]  held_we;
  logic [7:0]  exp_b;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
      end else begin
        if (valid_o && !prev_valid) begin
          if (exp_bus.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL bus_unexpected: valid_o with addr %h, no transaction expected", addr_o);
          end else begin
            e = exp_bus.pop_front();
            check("bus_addr", addr_o, e.addr);
            check("bus_we", 32'(we_o), 32'(e.we));
            if (e.we == 4'hF) check("bus_wdata", wdata_o, e.wdata);
          end
          held_addr  = addr_o;
          held_wdata = wdata_o;
          held_we    = we_o;
        end else if (valid_o) begin
          check("bus_hold_addr", addr_o, held_addr);
          check("bus_hold_wdata", wdata_o, held_wdata);
          check("bus_hold_we", 32'(we_o), 32'(held_we));
        end
        prev_valid = valid_o;

        if (tx_start_o) begin
          if (exp_tx.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected: tx byte %h, none expected", tx_byte_o);
          end else begin
            exp_b = exp_tx.pop_front();
            check("tx_byte", 32'(tx_byte_o), 32'(exp_b));
          end
        end
      end
    end
  end

  // ---------------- serial transmitter model ----------------
  initial begin
    tx_busy_i = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start_o && !rst) begin
        tx_busy_i = 1'b1;
        repeat ($urandom_range(1, 6)) @(negedge clk);
        tx_busy_i = 1'b0;
      end
    end
  end

  // ---------------- bus responder ----------------
  initial begin
    int          n;
    logic [31:0] rd;
    ready_i = 1'b0;
    rdata_i = 32'h0;
    forever begin
      @(negedge clk);
      if (valid_o && !rst) begin
        ready_i = 1'b0;
        n = (ready_delay_fixed >= 0) ? ready_delay_fixed : int'($urandom_range(3, 8));
        for (int k = 0; k < n && valid_o; k++) @(negedge clk);
        if (ready_hold) begin
          while (valid_o) @(negedge clk);
        end else if (valid_o) begin
          rd      = use_fixed_rdata ? fixed_rdata : $urandom;
          rdata_i = rd;
          ready_i = 1'b1;
          if (we_o == 4'h0) begin
            exp_tx.push_back(rd[7:0]);
            exp_tx.push_back(rd[15:8]);
            exp_tx.push_back(rd[23:16]);
            exp_tx.push_back(rd[31:24]);
          end
          @(negedge clk);
          ready_i = 1'b0;
        end
      end else begin
        // Stray completions while no request is pending must be ignored.
        ready_i = ($urandom_range(0, 7) == 0);
      end
      rdata_i = $urandom;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_byte(input logic [7:0] b, input bit err);
    @(negedge clk);
    rx_valid_i = 1'b1;
    rx_byte_i  = b;
    rx_error_i = err;
    @(negedge clk);
    rx_valid_i = 1'b0;
    rx_error_i = 1'b0;
    rx_byte_i  = 8'($urandom);
  endtask

  task automatic send_err_only();
    @(negedge clk);
    rx_error_i = 1'b1;
    @(negedge clk);
    rx_error_i = 1'b0;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while ((busy_o || tx_busy_i || exp_tx.size() != 0 || exp_bus.size() != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 3000) begin
      errors++;
      $display("FAIL %s_timeout: busy=%0d tx_q=%0d bus_q=%0d, required all idle", name, busy_o,
               exp_tx.size(), exp_bus.size());
      exp_tx.delete();
      exp_bus.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input bit junk);
    exp_bus.push_back('{a, d, 4'hF});
    exp_tx.push_back(8'h4B);
    send_byte(8'h57, 1'b0);
    for (int i = 0; i < 4; i++) begin gap(); send_byte(a[8*i +: 8], 1'b0); end
    for (int i = 0; i < 4; i++) begin gap(); send_byte(d[8*i +: 8], 1'b0); end
    // A byte arriving while the bus access is pending must be dropped.
    if (junk) send_byte(8'h57, 1'b0);
    wait_done("write");
  endtask

  task automatic do_read(input logic [31:0] a);
`ifdef UART_BUS_BRIDGE_READ_EN
    exp_bus.push_back('{a, 32'h0, 4'h0});
    send_byte(8'h52, 1'b0);
    for (int i = 0; i < 4; i++) begin gap(); send_byte(a[8*i +: 8], 1'b0); end
`else
    exp_tx.push_back(8'h3F);
    send_byte(8'h52, 1'b0);
`endif
    wait_done("read");
  endtask

  task automatic do_unknown(input logic [7:0] b);
    exp_tx.push_back(8'h3F);
    send_byte(b, 1'b0);
    wait_done("unknown");
  endtask

  // Frame aborted at byte position pos (1..4 address, 5..8 data).
  task automatic do_error(input int pos, input bit with_valid);
    send_byte(8'h57, 1'b0);
    for (int i = 1; i < pos; i++) begin gap(); send_byte(8'($urandom), 1'b0); end
    if (with_valid) send_byte(8'($urandom), 1'b1);
    else send_err_only();
    check("err_idle", 32'(busy_o), 32'd0);
    wait_done("error");
  endtask

  task automatic do_timeout(input int k);
    send_byte(8'h57, 1'b0);
    for (int i = 0; i < k; i++) send_byte(8'($urandom), 1'b0);
    repeat (8) @(negedge clk);
    check("tmo_still_busy", 32'(busy_o), 32'd1);
    repeat (12) @(negedge clk);
    check("tmo_idle", 32'(busy_o), 32'd0);
    wait_done("timeout");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] ub;
    int         sel;
    int         t;
    rst        = 1'b1;
    rx_valid_i = 1'b0;
    rx_error_i = 1'b0;
    rx_byte_i  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_tx_start", 32'(tx_start_o), 32'd0);
    check("rst_tx_byte", 32'(tx_byte_o), 32'd0);
    check("rst_addr", addr_o, 32'd0);
    check("rst_wdata", wdata_o, 32'd0);
    check("rst_we", 32'(we_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_busy", 32'(busy_o), 32'd0);

    // Directed vectors
    do_write(32'h0000_1000, 32'hDEAD_BEEF, 1'b0);
    use_fixed_rdata = 1'b1;
    fixed_rdata     = 32'h1234_5678;
    do_read(32'h0000_0004);
    use_fixed_rdata = 1'b0;
    do_unknown(8'h00);
    do_timeout(2);
    do_write(32'hA5A5_0001, 32'h0BAD_F00D, 1'b0);
    do_error(7, 1'b1);
    ready_delay_fixed = 50;
    do_write(32'h0000_2000, 32'h1122_3344, 1'b1);
    ready_delay_fixed = -1;

    // Reset while the bus request is outstanding: no response may follow.
    ready_hold = 1'b1;
    exp_bus.push_back('{32'h0000_3000, 32'hCAFE_0000, 4'hF});
    send_byte(8'h57, 1'b0);
    for (int i = 0; i < 4; i++) send_byte(8'(32'h0000_3000 >> (8*i)), 1'b0);
    for (int i = 0; i < 4; i++) send_byte(8'(32'hCAFE_0000 >> (8*i)), 1'b0);
    t = 0;
    while (!valid_o && t < 50) begin @(negedge clk); t++; end
    check("rst_bus_reached", 32'(valid_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_bus_valid", 32'(valid_o), 32'd0);
    check("rst_mid_bus_busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    rst        = 1'b0;
    ready_hold = 1'b0;
    check("rst_mid_bus_addr", addr_o, 32'd0);
    repeat (40) @(negedge clk);
    exp_bus.delete();

    // Randomized frames
    for (int it = 0; it < 60; it++) begin
      sel = int'($urandom_range(0, 9));
      case (sel)
        0, 1, 2: do_write($urandom, $urandom, 1'($urandom_range(0, 1)));
        3, 4:    do_read($urandom);
        5: begin
          ub = 8'($urandom);
          while (ub == 8'h57 || ub == 8'h52) ub = 8'($urandom);
          do_unknown(ub);
        end
        6, 7:    do_error(int'($urandom_range(1, 8)), 1'($urandom_range(0, 1)));
        default: do_timeout(int'($urandom_range(0, 3)));
      endcase
    end

    check("left_tx", 32'(exp_tx.size()), 32'd0);
    check("left_bus", 32'(exp_bus.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

`default_nettype wire
